// File: rtl/fb_access_scheduler_if.sv
// Framebuffer access bundle: display fetch, pixel writer, clear control and
// the single-port RAM port, grouped so the scheduler and its clients share
// one port list.
//
// Handshakes:
//   disp_req/disp_valid : disp_req is a one-cycle request that is always
//                         accepted; exactly one disp_valid pulse returns
//                         2 cycles later, in request order.
//   wr_req/wr_ack       : wr_req is a level with wr_addr/wr_data held stable
//                         until wr_ack; the edge that registers wr_ack is the
//                         edge that issues the write. wr_req still high on the
//                         next edge starts a new transaction.
//   clr_start/clr_busy  : a clr_start pulse seen while idle starts a clear;
//                         clr_busy stays high until the last word is issued.
interface fb_access_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Scheduler side.
    modport slave (
        input  disp_req, disp_addr, wr_req, wr_addr, wr_data,
               clr_start, clr_color, mem_rdata,
        output disp_data, disp_valid, wr_ack, clr_busy,
               mem_addr, mem_we, mem_wdata
    );

    // Client side: requesters plus the RAM read data.
    modport master (
        output disp_req, disp_addr, wr_req, wr_addr, wr_data,
               clr_start, clr_color, mem_rdata,
        input  disp_data, disp_valid, wr_ack, clr_busy,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_access_scheduler.sv
// Fixed-priority scheduler for one single-port framebuffer RAM.
// Display reads win every cycle, then the clear engine, then the pixel writer.
// All RAM-side outputs are registered; display data returns 2 cycles after the
// request edge.
module fb_access_scheduler #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int FB_DEPTH = 76800
) (
    input  logic                  clk,
    input  logic                  rst,
    fb_access_scheduler_if.slave  bus,
    output logic                  dbg_state
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(FB_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [DATA_W-1:0] clr_color_q;
    logic              rd_pend1_q;   // a display read is on the RAM this cycle
    logic              rd_pend2_q;   // its data is on mem_rdata this cycle

    logic grant_disp, grant_clr, grant_wr;
    logic clr_last, wr_in_range;

    // The ack register doubles as the "ack outstanding" blocker, which forces
    // at least one idle cycle between two writer grants.
    assign grant_disp  = bus.disp_req;
    assign grant_clr   = !bus.disp_req && (state_q == CLEAR);
    assign grant_wr    = !bus.disp_req && (state_q != CLEAR) && bus.wr_req && !bus.wr_ack;
    assign clr_last    = (clr_ptr_q == LAST_ADDR);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);

    assign bus.clr_busy = (state_q == CLEAR);
    assign dbg_state    = state_q;

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Clear FSM next state: leave CLEAR on the edge that grants the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr_start) state_d = CLEAR;
            CLEAR:   if (grant_clr && clr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear pointer and fill colour; the pointer only moves on a granted write
    // and parks on the last address instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr_q   <= '0;
            clr_color_q <= '0;
        end else if (state_q == IDLE && bus.clr_start) begin
            clr_ptr_q   <= '0;
            clr_color_q <= bus.clr_color;
        end else if (grant_clr && !clr_last) begin
            clr_ptr_q   <= clr_ptr_q + 1'b1;
        end
    end

    // RAM port registers driven by the arbitration winner; with no winner the
    // address holds and the write enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.wr_ack    <= 1'b0;
        end else begin
            bus.wr_ack <= grant_wr;
            if (grant_disp) begin
                bus.mem_addr <= bus.disp_addr;
                bus.mem_we   <= 1'b0;
            end else if (grant_clr) begin
                bus.mem_addr  <= clr_ptr_q;
                bus.mem_wdata <= clr_color_q;
                bus.mem_we    <= 1'b1;
            end else if (grant_wr) begin
                // Out-of-range writes are acknowledged but never reach the RAM.
                bus.mem_addr  <= bus.wr_addr;
                bus.mem_wdata <= bus.wr_data;
                bus.mem_we    <= wr_in_range;
            end else begin
                bus.mem_we <= 1'b0;
            end
        end
    end

    // Read-tracking pipeline: request edge -> RAM cycle -> data captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend1_q     <= 1'b0;
            rd_pend2_q     <= 1'b0;
            bus.disp_valid <= 1'b0;
            bus.disp_data  <= '0;
        end else begin
            rd_pend1_q     <= grant_disp;
            rd_pend2_q     <= rd_pend1_q;
            bus.disp_valid <= rd_pend2_q;
            if (rd_pend2_q) bus.disp_data <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_fb_access_scheduler.sv
// Bench for fb_access_scheduler: behavioural RAM, directed stimulus, and a
// monitor that pops expected display reads and writer acks from queues.
module tb_fb_access_scheduler;
  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 12000;
  localparam logic [31:0] DONT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  logic ram_init = 1'b0;
  logic wcnt_clr = 1'b0;

  fb_access_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_access_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram  [0:DEPTH-1];
  logic [7:0]    wcnt [0:DEPTH-1];

  function automatic logic [7:0] pat(input int a);
    if (a == 16) return 8'hA5;
    return 8'(a) ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < DEPTH; a++) begin
        ram[a]  <= pat(a);
        wcnt[a] <= 8'd0;
      end
    end else begin
      if (wcnt_clr) begin
        for (int a = 0; a < DEPTH; a++) wcnt[a] <= 8'd0;
      end else if (bus.mem_we && int'(bus.mem_addr) < DEPTH) begin
        ram[bus.mem_addr]  <= bus.mem_wdata;
        wcnt[bus.mem_addr] <= wcnt[bus.mem_addr] + 8'd1;
      end
    end
    bus.mem_rdata <= (int'(bus.mem_addr) < DEPTH) ? ram[bus.mem_addr] : '0;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  int busy_cnt = 0;
  logic busy_prev = 1'b0;
  logic [39:0] disp_q[$];   // {sample cycle, data}
  logic [57:0] wr_q[$];     // {ack cycle or DONT, we, addr, data}

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    logic [39:0] de;
    logic [57:0] we;
    if (!rst) begin
      if (bus.clr_busy) busy_cnt++;
      if (bus.disp_valid) begin
        if (disp_q.size() == 0) check("disp_unexpected", 1, 0);
        else begin
          de = disp_q.pop_front();
          check("disp_data", bus.disp_data, de[7:0]);
          check("disp_latency", cyc, de[39:8]);
        end
      end
      if (bus.wr_ack) begin
        ack_cnt++;
        check("wr_ack_during_clear", busy_prev, 0);
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          we = wr_q.pop_front();
          check("wr_mem_we", bus.mem_we, we[25]);
          if (we[25]) begin
            check("wr_mem_addr", bus.mem_addr, we[24:8]);
            check("wr_mem_wdata", bus.mem_wdata, we[7:0]);
          end
          if (we[57:26] != DONT) check("wr_ack_cycle", cyc, we[57:26]);
        end
      end
    end
    busy_prev = bus.clr_busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [AW-1:0] addr, input logic [7:0] data);
    bus.disp_req  = 1'b1;
    bus.disp_addr = addr;
    disp_q.push_back({32'(cyc + 3), data});
  endtask

  task automatic push_write(input logic [AW-1:0] addr, input logic [7:0] data, input logic [31:0] ack_cyc);
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    wr_q.push_back({ack_cyc, (int'(addr) < DEPTH), addr, data});
  endtask

  task automatic wait_ack(input int limit);
    bit got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      tick();
      if (bus.wr_ack) got = 1;
    end
    bus.wr_req = 1'b0;
    if (!got) check("wr_ack_timeout", 0, 1);
  endtask

  task automatic start_clear(input logic [7:0] color);
    bus.clr_start = 1'b1;
    bus.clr_color = color;
    tick();
    bus.clr_start = 1'b0;
  endtask

  function automatic int ram_bad(input int split, input logic [7:0] lo, input logic [7:0] hi,
                                 input int skip_addr, input logic [7:0] skip_val);
    int bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (a == skip_addr) begin
        if (ram[a] !== skip_val) bad++;
      end else if (ram[a] !== ((a < split) ? lo : hi)) bad++;
    end
    return bad;
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0] burst_exp [8];
  int s_edge;
  int n_steal;
  int bad;
  int ack_base;

  initial begin
    burst_exp = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C, 8'h5D};
    bus.disp_req = 0; bus.disp_addr = '0;
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_start = 0; bus.clr_color = '0;

    // Reset for 3 cycles; a clr_start during reset must be ignored.
    rst = 1'b1; ram_init = 1'b1;
    tick();
    ram_init = 1'b0;
    tick();
    bus.clr_start = 1'b1; bus.clr_color = 8'h33;
    tick();
    rst = 1'b0; bus.clr_start = 1'b0;
    @(negedge clk);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_disp_data", bus.disp_data, 0);
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_clr_busy", bus.clr_busy, 0);
    tick();
    check("clr_start_with_rst_ignored", bus.clr_busy, 0);

    // Single display read of the preloaded word.
    push_read(17'h00010, 8'hA5);
    tick();
    bus.disp_req = 1'b0;
    repeat (4) tick();

    // 8-read burst with a writer waiting behind it: ack on the edge after the burst.
    push_write(17'h00100, 8'h66, 32'(cyc + 9));
    for (int i = 0; i < 8; i++) begin
      push_read(AW'(i), burst_exp[i]);
      tick();
    end
    bus.disp_req = 1'b0;
    wait_ack(20);
    repeat (4) tick();

    // Writer held 6 cycles: acks on alternate cycles.
    ack_base = ack_cnt;
    push_write(17'h012C0, 8'h3C, 32'(cyc + 1));
    wr_q.push_back({32'(cyc + 3), 1'b1, 17'h012C0, 8'h3C});
    wr_q.push_back({32'(cyc + 5), 1'b1, 17'h012C0, 8'h3C});
    repeat (6) tick();
    bus.wr_req = 1'b0;
    repeat (3) tick();
    check("held_writer_ack_count", ack_cnt - ack_base, 3);

    // Full clear with no display traffic; a writer waits it out.
    wcnt_clr = 1'b1;
    tick();
    wcnt_clr = 1'b0;
    busy_cnt = 0;
    s_edge = cyc + 1;
    start_clear(8'h1F);
    repeat (3) tick();
    push_write(17'd5, 8'h99, 32'(s_edge + DEPTH + 1));
    wait_ack(DEPTH + 50);
    repeat (3) tick();
    check("clear_busy_cycles", busy_cnt, DEPTH);
    check("clear_ram_contents", ram_bad(0, 8'h1F, 8'h1F, 5, 8'h99), 0);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (wcnt[a] != ((a == 5) ? 8'd2 : 8'd1)) bad++;
    check("clear_write_counts", bad, 0);

    // Clear started alongside a display read, then display every 4th cycle
    // and a stray clr_start mid-clear that must be ignored.
    wcnt_clr = 1'b1;
    tick();
    wcnt_clr = 1'b0;
    busy_cnt = 0;
    n_steal = 0;
    push_read(17'd5, 8'h99);
    start_clear(8'h1F);
    bus.disp_req = 1'b0;
    for (int i = 1; i < 2 * DEPTH; i++) begin
      bus.disp_req  = 1'b0;
      bus.clr_start = 1'b0;
      if (!bus.clr_busy) break;
      if (i == 10) begin
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h44;
      end
      if (i % 4 == 0) begin
        push_read(AW'(100 + i % 50), 8'h1F);
        n_steal++;
      end
      tick();
    end
    bus.disp_req = 1'b0;
    repeat (4) tick();
    check("stalled_clear_busy_cycles", busy_cnt, DEPTH + n_steal);
    check("stalled_clear_ram", ram_bad(0, 8'h1F, 8'h1F, -1, 8'h00), 0);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (wcnt[a] != 8'd1) bad++;
    check("stalled_clear_each_addr_once", bad, 0);

    // Reset while the clear pointer sits at 1000.
    start_clear(8'h77);
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    check("busy_after_rst", bus.clr_busy, 0);
    check("we_after_rst", bus.mem_we, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("clear_not_resumed", bus.clr_busy, 0);
    check("aborted_clear_ram", ram_bad(1000, 8'h77, 8'h1F, -1, 8'h00), 0);

    // Out-of-range writer address: acked, no write.
    push_write(AW'(DEPTH), 8'h42, DONT);
    wait_ack(10);
    repeat (3) tick();
    check("oor_ram_untouched", ram_bad(1000, 8'h77, 8'h1F, -1, 8'h00), 0);

    repeat (5) tick();
    check("disp_queue_drained", disp_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
